// File: rtl/pe_dot_seq.sv
// pe_dot_seq: bus-master sequencer that runs signed dot products on the memory-mapped PE.
// Optional busy-cycle counter is built when PE_DOT_SEQ_PERF_EN is defined.
module pe_dot_seq #(
    parameter int DEPTH    = 8,
    parameter int POLL_MAX = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid_i,
    output logic        op_ready_o,
    input  logic [7:0]  op_a_i,
    input  logic [7:0]  op_b_i,
    input  logic        op_last_i,
    input  logic        op_relu_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [31:0] res_data_o,
    output logic        res_err_o,
    output logic        busy_o,
    output logic        pe_req_o,
    output logic [3:0]  pe_wen_o,
    output logic [2:0]  pe_addr_o,
    output logic [31:0] pe_wdata_o,
    input  logic [31:0] pe_rdata_i,
    output logic [31:0] perf_cycles_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(POLL_MAX + 1);

    localparam logic [2:0]  ADDR_A      = 3'd0;
    localparam logic [2:0]  ADDR_B      = 3'd1;
    localparam logic [2:0]  ADDR_CTRL   = 3'd2;
    localparam logic [2:0]  ADDR_RES    = 3'd3;
    localparam logic [2:0]  ADDR_STATUS = 3'd4;
    localparam logic [3:0]  WEN_WRITE   = 4'hF;
    localparam logic [31:0] CTRL_CLEAR  = 32'h0000_0004;

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_WR_A, S_WR_B, S_WR_GO, S_POLL_RQ, S_POLL_CK,
        S_RD_RQ, S_RD_CK, S_OUT, S_ERR
    } state_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       last;
        logic       relu;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, empty;
    entry_t        head;

    state_t        state_q, state_d;
    logic          first_q, last_q;
    logic [PW-1:0] poll_cnt_q;
    logic [31:0]   res_data_q;
    logic          res_err_q;

    assign empty      = (count == '0);
    assign op_ready_o = !reset && (count != (AW + 1)'(DEPTH));
    assign push       = op_valid_i && op_ready_o;
    assign head       = mem[rd_ptr];

    // NOTE: the storage array is deliberately not reset; pointers and count alone define contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{a: op_a_i, b: op_b_i, last: op_last_i, relu: op_relu_i};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        pe_req_o   = 1'b0;
        pe_wen_o   = 4'h0;
        pe_addr_o  = 3'd0;
        pe_wdata_o = 32'h0;
        case (state_q)
            S_IDLE: if (!empty) state_d = first_q ? S_CLR : S_WR_A;
            S_CLR: begin
                pe_req_o   = 1'b1;
                pe_wen_o   = WEN_WRITE;
                pe_addr_o  = ADDR_CTRL;
                pe_wdata_o = CTRL_CLEAR;
                state_d    = S_WR_A;
            end
            S_WR_A: begin
                pe_req_o   = 1'b1;
                pe_wen_o   = WEN_WRITE;
                pe_addr_o  = ADDR_A;
                pe_wdata_o = {24'h0, head.a};
                state_d    = S_WR_B;
            end
            S_WR_B: begin
                pe_req_o   = 1'b1;
                pe_wen_o   = WEN_WRITE;
                pe_addr_o  = ADDR_B;
                pe_wdata_o = {{24{head.b[7]}}, head.b};
                state_d    = S_WR_GO;
            end
            S_WR_GO: begin
                pe_req_o   = 1'b1;
                pe_wen_o   = WEN_WRITE;
                pe_addr_o  = ADDR_CTRL;
                pe_wdata_o = {30'h0, head.last & head.relu, 1'b1};
                pop        = 1'b1;
                state_d    = S_POLL_RQ;
            end
            S_POLL_RQ: begin
                pe_req_o  = 1'b1;
                pe_addr_o = ADDR_STATUS;
                state_d   = S_POLL_CK;
            end
            S_POLL_CK: begin
                if (pe_rdata_i[0])                       state_d = last_q ? S_RD_RQ : S_IDLE;
                else if (poll_cnt_q == PW'(POLL_MAX - 1)) state_d = S_ERR;
                else                                     state_d = S_POLL_RQ;
            end
            S_RD_RQ: begin
                pe_req_o  = 1'b1;
                pe_addr_o = ADDR_RES;
                state_d   = S_RD_CK;
            end
            S_RD_CK: state_d = S_OUT;
            S_OUT:   if (res_ready_i) state_d = S_IDLE;
            S_ERR: begin
                // Drain the rest of the aborted vector so the next one starts on a clean boundary.
                if (last_q) begin
                    state_d = S_OUT;
                end else if (!empty) begin
                    pop = 1'b1;
                    if (head.last) state_d = S_OUT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            first_q    <= 1'b1;
            last_q     <= 1'b0;
            poll_cnt_q <= '0;
            res_data_q <= 32'h0;
            res_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_WR_GO: begin
                    last_q     <= head.last;
                    poll_cnt_q <= '0;
                end
                S_POLL_CK: begin
                    if (!pe_rdata_i[0]) poll_cnt_q <= poll_cnt_q + 1'b1;
                    else if (!last_q)   first_q    <= 1'b0;
                end
                S_RD_CK: begin
                    res_data_q <= pe_rdata_i;
                    res_err_q  <= 1'b0;
                end
                S_ERR: begin
                    res_data_q <= 32'h0;
                    res_err_q  <= 1'b1;
                end
                S_OUT: if (res_ready_i) first_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign res_valid_o = (state_q == S_OUT);
    assign res_data_o  = res_data_q;
    assign res_err_o   = res_err_q;

`ifdef PE_DOT_SEQ_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                         perf_q <= 32'h0;
        else if (busy_o && perf_q != '1)   perf_q <= perf_q + 1'b1;
    end

    assign perf_cycles_o = perf_q;
`else
    assign perf_cycles_o = 32'h0;
`endif

endmodule

// File: tb/tb_pe_dot_seq.sv
// Testbench for pe_dot_seq: a PE bus stub plus directed and randomized vectors checked
// against plain-arithmetic dot products and the expected bus transaction sequence.
module tb_pe_dot_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid_i = 1'b0;
    logic        op_ready_o;
    logic [7:0]  op_a_i = 8'h0;
    logic [7:0]  op_b_i = 8'h0;
    logic        op_last_i = 1'b0;
    logic        op_relu_i = 1'b0;
    logic        res_valid_o;
    logic        res_ready_i = 1'b0;
    logic [31:0] res_data_o;
    logic        res_err_o;
    logic        busy_o;
    logic        pe_req_o;
    logic [3:0]  pe_wen_o;
    logic [2:0]  pe_addr_o;
    logic [31:0] pe_wdata_o;
    logic [31:0] pe_rdata_i = 32'h0;
    logic [31:0] perf_cycles_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pe_dot_seq #(.DEPTH(8), .POLL_MAX(50)) dut (
        .clk(clk), .reset(reset),
        .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
        .op_a_i(op_a_i), .op_b_i(op_b_i), .op_last_i(op_last_i), .op_relu_i(op_relu_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_data_o(res_data_o), .res_err_o(res_err_o), .busy_o(busy_o),
        .pe_req_o(pe_req_o), .pe_wen_o(pe_wen_o), .pe_addr_o(pe_addr_o),
        .pe_wdata_o(pe_wdata_o), .pe_rdata_i(pe_rdata_i),
        .perf_cycles_o(perf_cycles_o)
    );

    // PE model: A/B/CTRL/RES/STATUS registers, read data returned one cycle after the request.
    logic [31:0] pe_a = 32'h0, pe_b = 32'h0, pe_acc = 32'h0;
    logic        pe_mode = 1'b0;
    int          pe_wait = 0;
    bit          stall = 1'b0;
    bit          rnd_status = 1'b0;
    int          fixed_wait = 0;

    always @(posedge clk) begin
        pe_rdata_i <= $urandom;
        if (pe_req_o && pe_wen_o == 4'hF) begin
            case (pe_addr_o)
                3'd0: pe_a <= pe_wdata_o;
                3'd1: pe_b <= pe_wdata_o;
                3'd2: begin
                    if (pe_wdata_o[2]) begin
                        pe_acc <= 32'h0;
                    end else if (pe_wdata_o[0]) begin
                        pe_acc  <= pe_acc + pe_a * pe_b;
                        pe_mode <= pe_wdata_o[1];
                        pe_wait <= rnd_status ? int'($urandom_range(0, 3)) : fixed_wait;
                    end
                end
                default: ;
            endcase
        end else if (pe_req_o && pe_wen_o == 4'h0) begin
            if (pe_addr_o == 3'd4) begin
                pe_rdata_i <= {31'h0, (!stall && pe_wait == 0)};
                if (pe_wait > 0) pe_wait <= pe_wait - 1;
            end else if (pe_addr_o == 3'd3) begin
                pe_rdata_i <= (pe_mode && pe_acc[31]) ? 32'h0 : pe_acc;
            end
        end
    end

    // Bus log: {wen, addr, wdata}; read data field is masked to 0.
    logic [38:0] log_q [$];
    int          busy_cnt = 0;

    always @(negedge clk) begin
        if (!reset && pe_req_o)
            log_q.push_back({pe_wen_o, pe_addr_o, (pe_wen_o == 4'hF) ? pe_wdata_o : 32'h0});
        if (reset)       busy_cnt = 0;
        else if (busy_o) busy_cnt++;
    end

    function automatic logic [38:0] bw(input logic [2:0] ad, input logic [31:0] d);
        return {4'hF, ad, d};
    endfunction

    function automatic logic [38:0] br(input logic [2:0] ad);
        return {4'h0, ad, 32'h0};
    endfunction

    function automatic int count_exact(input logic [38:0] e);
        int n = 0;
        foreach (log_q[i]) if (log_q[i] == e) n++;
        return n;
    endfunction

    function automatic int count_hits(input logic [6:0] key);
        int n = 0;
        foreach (log_q[i]) if (log_q[i][38:32] == key) n++;
        return n;
    endfunction

    function automatic logic [31:0] last_ctrl();
        logic [31:0] v = 32'hFFFF_FFFF;
        foreach (log_q[i]) if (log_q[i][38:32] == {4'hF, 3'd2}) v = log_q[i][31:0];
        return v;
    endfunction

    function automatic logic [38:0] log_at(input int i);
        return (i < log_q.size()) ? log_q[i] : 39'h0;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 64'({op_ready_o, res_valid_o, res_err_o, busy_o, pe_req_o, pe_wen_o, pe_addr_o}), 64'h0);
        check({tag, "_data"}, {res_data_o, pe_wdata_o}, 64'h0);
        check({tag, "_perf"}, 64'(perf_cycles_o), 64'h0);
    endtask

    task automatic push_pair(input logic [7:0] a, input logic [7:0] b, input bit last, input bit relu);
        int n = 0;
        @(negedge clk);
        while (!op_ready_o && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready_o) check("push_ready", 64'(op_ready_o), 64'h1);
        op_valid_i = 1'b1;
        op_a_i     = a;
        op_b_i     = b;
        op_last_i  = last;
        op_relu_i  = relu;
        @(negedge clk);
        op_valid_i = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [31:0] exp_data, input logic exp_err, input int hold);
        int n = 0;
        logic [31:0] first_data;
        while (!res_valid_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 64'(res_valid_o), 64'h1);
        first_data = res_data_o;
        repeat (hold) @(negedge clk);
        check({tag, "_hold"}, 64'(res_valid_o), 64'h1);
        check({tag, "_stable"}, 64'(res_data_o), 64'(first_data));
        check({tag, "_data"}, 64'(res_data_o), 64'(exp_data));
        check({tag, "_err"}, 64'(res_err_o), 64'(exp_err));
        res_ready_i = 1'b1;
        @(negedge clk);
        res_ready_i = 1'b0;
        check({tag, "_acc"}, 64'(res_valid_o), 64'h0);
    endtask

    initial begin
        logic [38:0] t1_exp [6];
        logic [31:0] e;
        int          sum;
        int          n;
        bit          found;

        repeat (3) @(negedge clk);
        check_all_zero("rst");
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(op_ready_o), 64'h1);
        check("rst_busy", 64'(busy_o), 64'h0);

        // Single-pair vector: full bus sequence.
        log_q.delete();
        push_pair(8'd5, 8'd3, 1'b1, 1'b0);
        wait_result("t1", 32'd15, 1'b0, 0);
        t1_exp[0] = bw(3'd2, 32'h4);
        t1_exp[1] = bw(3'd0, 32'd5);
        t1_exp[2] = bw(3'd1, 32'd3);
        t1_exp[3] = bw(3'd2, 32'h1);
        t1_exp[4] = br(3'd4);
        t1_exp[5] = br(3'd3);
        check("t1_bus_len", 64'(log_q.size()), 64'd6);
        for (int i = 0; i < 6; i++) check($sformatf("t1_bus%0d", i), 64'(log_at(i)), 64'(t1_exp[i]));

        // Two-pair vector, then the same with ReLU on the last pair.
        log_q.delete();
        push_pair(8'd10, 8'hFE, 1'b0, 1'b0);
        push_pair(8'd7, 8'd1, 1'b1, 1'b0);
        wait_result("t2", 32'hFFFF_FFF3, 1'b0, 0);
        check("t2_clr_once", 64'(count_exact(bw(3'd2, 32'h4))), 64'd1);
        check("t2_b_neg", 64'(count_exact(bw(3'd1, 32'hFFFF_FFFE))), 64'd1);

        log_q.delete();
        push_pair(8'd10, 8'hFE, 1'b0, 1'b0);
        push_pair(8'd7, 8'd1, 1'b1, 1'b1);
        wait_result("t2r", 32'h0, 1'b0, 0);
        check("t2r_last_ctrl", 64'(last_ctrl()), 64'h3);
        check("t2r_plain_go", 64'(count_exact(bw(3'd2, 32'h1))), 64'd1);

        // Operand extremes.
        log_q.delete();
        push_pair(8'd255, 8'd127, 1'b0, 1'b0);
        push_pair(8'd255, 8'h80, 1'b1, 1'b0);
        wait_result("corner", 32'hFFFF_FF01, 1'b0, 0);
        check("corner_b80", 64'(count_exact(bw(3'd1, 32'hFFFF_FF80))), 64'd1);
        check("corner_a255", 64'(count_exact(bw(3'd0, 32'h0000_00FF))), 64'd2);

        // FIFO fills while the result port is stalled.
        push_pair(8'd1, 8'd1, 1'b1, 1'b0);
        n = 0;
        while (!res_valid_o && n < 500) begin
            @(negedge clk);
            n++;
        end
        sum = 0;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] a, b;
            a = 8'(i * 31 + 5);
            b = 8'(i * 19 - 70);
            sum += int'(a) * int'($signed(b));
            push_pair(a, b, (i == 7), 1'b0);
        end
        check("fifo_full", 64'(op_ready_o), 64'h0);
        wait_result("fifo_v1", 32'd1, 1'b0, 10);
        e = sum;
        wait_result("fifo_v2", e, 1'b0, 0);

        // Poll timeout on the first of three pairs, then a clean vector.
        stall = 1'b1;
        log_q.delete();
        push_pair(8'd3, 8'd3, 1'b0, 1'b0);
        push_pair(8'd4, 8'd4, 1'b0, 1'b0);
        push_pair(8'd5, 8'd5, 1'b1, 1'b0);
        wait_result("tmo", 32'h0, 1'b1, 0);
        check("tmo_polls", 64'(count_hits({4'h0, 3'd4})), 64'd50);
        check("tmo_a_writes", 64'(count_hits({4'hF, 3'd0})), 64'd1);
        stall = 1'b0;
        repeat (3) @(negedge clk);
        check("tmo_drained", 64'(busy_o), 64'h0);
        log_q.delete();
        push_pair(8'd6, 8'd7, 1'b1, 1'b0);
        wait_result("tmo_next", 32'd42, 1'b0, 0);
        check("tmo_next_clr", 64'(log_at(0)), 64'(bw(3'd2, 32'h4)));

        // Reset while writing B of the second pair.
        fixed_wait = 6;
        log_q.delete();
        push_pair(8'd9, 8'd9, 1'b0, 1'b0);
        push_pair(8'd8, 8'd20, 1'b0, 1'b0);
        push_pair(8'd7, 8'd7, 1'b0, 1'b0);
        push_pair(8'd6, 8'd6, 1'b1, 1'b0);
        found = 1'b0;
        n = 0;
        while (!found && n < 500) begin
            @(negedge clk);
            found = pe_req_o && pe_wen_o == 4'hF && pe_addr_o == 3'd1 && pe_wdata_o == 32'd20;
            n++;
        end
        check("rstmid_seen_wr_b", 64'(found), 64'h1);
        reset = 1'b1;
        #1;
        check_all_zero("rstmid");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        fixed_wait = 0;
        log_q.delete();
        push_pair(8'd2, 8'd2, 1'b1, 1'b0);
        wait_result("rstmid_next", 32'd4, 1'b0, 0);
        check("rstmid_next_clr", 64'(log_at(0)), 64'(bw(3'd2, 32'h4)));

        // Randomized vectors against plain arithmetic.
        rnd_status = 1'b1;
        for (int v = 0; v < 10; v++) begin
            int  len;
            bit  relu;
            len  = int'($urandom_range(1, 5));
            relu = 1'($urandom_range(0, 1));
            sum  = 0;
            log_q.delete();
            for (int i = 0; i < len; i++) begin
                logic [7:0] a, b;
                a = 8'($urandom);
                b = 8'($urandom);
                sum += int'(a) * int'($signed(b));
                push_pair(a, b, (i == len - 1), relu);
            end
            e = (relu && sum < 0) ? 32'h0 : sum;
            wait_result($sformatf("rnd%0d", v), e, 1'b0, int'($urandom_range(0, 3)));
            check($sformatf("rnd%0d_clr", v), 64'(count_exact(bw(3'd2, 32'h4))), 64'd1);
            check($sformatf("rnd%0d_a_writes", v), 64'(count_hits({4'hF, 3'd0})), 64'(len));
        end
        rnd_status = 1'b0;

        repeat (3) @(negedge clk);
`ifdef PE_DOT_SEQ_PERF_EN
        check("perf_cycles", 64'(perf_cycles_o), 64'(busy_cnt));
`else
        check("perf_off", 64'(perf_cycles_o), 64'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
